hazard_ctrl: RTL and testbench

Pipeline control unit for the five-stage core. It generates stall, flush and redirect controls for the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, covering load-use hazards, EX-stage branch redirects, multi-cycle EX operations and memory wait states. It sits beside the datapath and drives every pipeline register's `stall`/`flush` inputs. It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

---
 rtl/hazard_pkg.sv | 69 ++++++
 rtl/hazard_detect.sv | 21 ++
 rtl/hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard control unit.
package hazard_pkg;

  // Register index width used by the load-use comparator.
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  // One bundle of every pipeline-register control the unit drives.
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic mem_wb_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic redirect;
  } hz_ctrl_t;

  // Memory freeze: hold every register, nothing moves.
  function automatic hz_ctrl_t ctrl_freeze();
    hz_ctrl_t c;
    c              = '0;
    c.pc_stall     = 1'b1;
    c.if_id_stall  = 1'b1;
    c.id_ex_stall  = 1'b1;
    c.ex_mem_stall = 1'b1;
    c.mem_wb_stall = 1'b1;
    return c;
  endfunction

  // Taken branch in EX: steer the PC and squash the two younger instructions.
  function automatic hz_ctrl_t ctrl_branch();
    hz_ctrl_t c;
    c             = '0;
    c.redirect    = 1'b1;
    c.if_id_flush = 1'b1;
    c.id_ex_flush = 1'b1;
    return c;
  endfunction

  // Multi-cycle op busy: hold the front, feed bubbles into MEM.
  function automatic hz_ctrl_t ctrl_mc();
    hz_ctrl_t c;
    c              = '0;
    c.pc_stall     = 1'b1;
    c.if_id_stall  = 1'b1;
    c.id_ex_stall  = 1'b1;
    c.ex_mem_flush = 1'b1;
    return c;
  endfunction

  // Load-use: hold PC and IF/ID, insert a bubble into EX.
  function automatic hz_ctrl_t ctrl_load_use();
    hz_ctrl_t c;
    c             = '0;
    c.pc_stall    = 1'b1;
    c.if_id_stall = 1'b1;
    c.id_ex_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator; also reused by the forwarding unit.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  output logic              load_use
);

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  always_comb begin
    load_use = ex_is_load && (ex_rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: stall/flush/redirect generation for the five-stage
// core, plus a saturating stall-cycle counter and a sticky memory-timeout flag.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 1024,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_branch_taken,
  input  logic              ex_mc_start,
  input  logic              ex_mc_done,
  input  logic              im_ready,
  input  logic              dm_req,
  input  logic              dm_ready,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_stall,
  output logic              ex_mem_stall,
  output logic              mem_wb_stall,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              redirect,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              mem_timeout
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

  hz_state_e        state_q, state_d, eff_state;
  logic             mc_pend_q, mc_pend_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic             freeze, load_use;
  hz_ctrl_t         ctrl, ctrl_out;

  hazard_detect u_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .load_use   (load_use)
  );

  assign freeze = !im_ready || (dm_req && !dm_ready);

  // Next-state and Mealy outputs. MEM_WAIT behaves like the state it will
  // return to once the freeze lifts, so resolve that state first.
  always_comb begin
    // NOTE: every variable gets a default before any branch, otherwise an
    // unassigned path infers a latch.
    eff_state = state_q;
    ctrl      = '0;
    state_d   = state_q;
    mc_pend_d = mc_pend_q;
    if (state_q == MEM_WAIT) eff_state = mc_pend_q ? MC_WAIT : RUN;

    if (freeze) begin
      ctrl      = ctrl_freeze();
      state_d   = MEM_WAIT;
      mc_pend_d = (eff_state == MC_WAIT);
    end else begin
      mc_pend_d = 1'b0;
      case (eff_state)
        MC_WAIT: begin
          if (ex_mc_done) begin
            state_d = RUN;
          end else begin
            ctrl    = ctrl_mc();
            state_d = MC_WAIT;
          end
        end
        default: begin
          state_d = RUN;
          if (ex_branch_taken) begin
            ctrl = ctrl_branch();
          end else if (ex_mc_start) begin
            if (!ex_mc_done) begin
              ctrl    = ctrl_mc();
              state_d = MC_WAIT;
            end
          end else if (load_use) begin
            ctrl = ctrl_load_use();
          end
        end
      endcase
    end
  end

  // Controls are forced quiet while reset is held.
  assign ctrl_out = rst ? ctrl : '0;

  // Counter and sticky-flag updates.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ctrl_out.pc_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;

    tmo_cnt_d = '0;
    if (state_d == MEM_WAIT)
      tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;

    mem_timeout_d = mem_timeout_q || (tmo_cnt_d == TMO_MAX);
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    if (!rst) begin
      state_q       <= RUN;
      mc_pend_q     <= 1'b0;
      tmo_cnt_q     <= '0;
      stall_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mc_pend_q     <= mc_pend_d;
      tmo_cnt_q     <= tmo_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign pc_stall     = ctrl_out.pc_stall;
  assign if_id_stall  = ctrl_out.if_id_stall;
  assign id_ex_stall  = ctrl_out.id_ex_stall;
  assign ex_mem_stall = ctrl_out.ex_mem_stall;
  assign mem_wb_stall = ctrl_out.mem_wb_stall;
  assign if_id_flush  = ctrl_out.if_id_flush;
  assign id_ex_flush  = ctrl_out.id_ex_flush;
  assign ex_mem_flush = ctrl_out.ex_mem_flush;
  assign redirect     = ctrl_out.redirect;
  assign stall_cnt    = stall_cnt_q;
  assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed expected controls.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken;
  logic       ex_mc_start, ex_mc_done, im_ready, dm_req, dm_ready;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, redirect;
  logic [3:0] stall_cnt;
  logic       mem_timeout;

  int total = 0;
  int bad   = 0;

  // Control vector order: pc,if_id,id_ex,ex_mem,mem_wb stalls | if_id,id_ex,ex_mem flush | redirect
  localparam logic [8:0] NONE  = 9'b00000_000_0;
  localparam logic [8:0] ALLST = 9'b11111_000_0;
  localparam logic [8:0] BR    = 9'b00000_110_1;
  localparam logic [8:0] MC    = 9'b11100_001_0;
  localparam logic [8:0] LU    = 9'b11000_010_0;

  hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
    .im_ready(im_ready), .dm_req(dm_req), .dm_ready(dm_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .redirect(redirect), .stall_cnt(stall_cnt), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ctl();
    return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
            if_id_flush, id_ex_flush, ex_mem_flush, redirect};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_is_load = 0; ex_branch_taken = 0;
    ex_mc_start = 0; ex_mc_done = 0;
    im_ready = 1; dm_req = 0; dm_ready = 1;
  endtask

  // Advance one clock; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    #3;
    rst = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    im_ready = 1'b0;           // a freeze request must not leak through reset
    #2;
    check("rst_ctl", 32'(ctl()), 32'(NONE));
    check("rst_cnt", 32'(stall_cnt), 0);
    check("rst_tmo", 32'(mem_timeout), 0);
    im_ready = 1'b1;
    #1; rst = 1'b1;
    tick();
    check("run_idle", 32'(ctl()), 32'(NONE));

    // Load-use on rs1, exactly one cycle
    ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; #1;
    check("lu_rs1", 32'(ctl()), 32'(LU));
    tick();
    ex_is_load = 0; #1;                    // load moved to MEM
    check("lu_after", 32'(ctl()), 32'(NONE));
    check("lu_cnt", 32'(stall_cnt), 1);
    ex_is_load = 1; ex_rd = 0; id_rs1 = 0; #1;
    check("lu_x0", 32'(ctl()), 32'(NONE));
    ex_rd = 7; id_rs1 = 3; id_rs2 = 7; id_use_rs2 = 1; #1;
    check("lu_rs2", 32'(ctl()), 32'(LU));
    id_use_rs2 = 0; #1;
    check("lu_unused", 32'(ctl()), 32'(NONE));

    // Branch wins over simultaneous load-use
    id_use_rs2 = 1; ex_branch_taken = 1; #1;
    check("br_lu", 32'(ctl()), 32'(BR));
    tick();
    idle(); #1;
    check("br_cnt", 32'(stall_cnt), 1);

    // Multi-cycle op: start at cycle 0, done at cycle 4
    do_reset();
    ex_mc_start = 1; #1;
    check("mc_c0", 32'(ctl()), 32'(MC));
    tick();
    ex_mc_start = 0;
    ex_branch_taken = 1; #1;               // ignored while MC busy
    check("mc_c1_br", 32'(ctl()), 32'(MC));
    ex_branch_taken = 0;
    for (int i = 2; i < 4; i++) begin
      tick(); #1;
      check($sformatf("mc_c%0d", i), 32'(ctl()), 32'(MC));
    end
    tick();
    ex_mc_done = 1; #1;
    check("mc_done", 32'(ctl()), 32'(NONE));
    tick();
    ex_mc_done = 0; #1;
    check("mc_back", 32'(ctl()), 32'(NONE));
    check("mc_cnt", 32'(stall_cnt), 4);

    // Start and done in the same cycle: no stall, stays RUN
    ex_mc_start = 1; ex_mc_done = 1; #1;
    check("mc_same", 32'(ctl()), 32'(NONE));
    tick();
    idle(); #1;
    check("mc_same_nx", 32'(ctl()), 32'(NONE));

    // Memory wait inside MC_WAIT resumes MC_WAIT
    do_reset();
    ex_mc_start = 1; tick();
    ex_mc_start = 0; dm_req = 1; dm_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1; check($sformatf("mcmem_fz%0d", i), 32'(ctl()), 32'(ALLST));
      tick();
    end
    dm_req = 0; dm_ready = 1; #1;
    check("mcmem_resume", 32'(ctl()), 32'(MC));
    tick();
    ex_mc_done = 1; #1;
    check("mcmem_done", 32'(ctl()), 32'(NONE));
    tick();
    idle(); #1;
    check("mcmem_run", 32'(ctl()), 32'(NONE));
    check("mcmem_cnt", 32'(stall_cnt), 5);

    // Freeze with a taken branch defers the redirect, issued exactly once
    do_reset();
    im_ready = 0; ex_branch_taken = 1; #1;
    check("fzbr_0", 32'(ctl()), 32'(ALLST));
    tick(); #1;
    check("fzbr_1", 32'(ctl()), 32'(ALLST));
    im_ready = 1; #1;
    check("fzbr_go", 32'(ctl()), 32'(BR));
    tick();
    ex_branch_taken = 0; #1;
    check("fzbr_after", 32'(ctl()), 32'(NONE));

    // Memory timeout after 8 frozen cycles, sticky afterwards
    do_reset();
    im_ready = 0;
    for (int k = 0; k < 10; k++) begin
      #1; check($sformatf("tmo_k%0d", k), 32'(mem_timeout), (k >= 8) ? 1 : 0);
      tick();
    end
    im_ready = 1; #1;
    check("tmo_rel_ctl", 32'(ctl()), 32'(NONE));
    check("tmo_cnt10", 32'(stall_cnt), 10);
    tick(); tick(); #1;
    check("tmo_sticky", 32'(mem_timeout), 1);

    // Stall counter saturates at all-ones
    im_ready = 0;
    for (int i = 0; i < 10; i++) tick();
    #1;
    check("cnt_sat", 32'(stall_cnt), 15);

    // Reset pulsed mid-MEM_WAIT clears everything at once
    rst = 1'b0; #1;
    check("rstfz_ctl", 32'(ctl()), 32'(NONE));
    check("rstfz_cnt", 32'(stall_cnt), 0);
    check("rstfz_tmo", 32'(mem_timeout), 0);
    im_ready = 1; #1;
    rst = 1'b1;
    tick(); #1;
    check("rstfz_run", 32'(ctl()), 32'(NONE));
    check("rstfz_cnt2", 32'(stall_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
